spi_slave_ctrl: RTL

Parametrised full-duplex SPI target controller. It runs on the system clock and oversamples the external SCK, CS_n and MOSI pins. It supports all four CPOL/CPHA modes, a configurable word width and bit order, a TX holding register with a valid/ready handshake, and a per-word RX strobe. It sits between the SPI pins and the system-side register or command logic, and is the next generation of the plain MOSI shift-in receiver.

---
 rtl/spi_slave_ctrl_pkg.sv | 27 ++
 rtl/spi_slave_ctrl_if.sv | 30 +++
 rtl/spi_slave_ctrl_sync.sv | 24 ++
 rtl/spi_slave_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/spi_slave_ctrl_pkg.sv
// Shared definitions for the SPI target controller: FSM states, SPI mode codes
// and SCK edge-classification helpers.
// Latency: none (types and pure functions). Backpressure: n/a.
package spi_pkg;

    typedef enum logic {
        SPI_IDLE   = 1'b0,
        SPI_ACTIVE = 1'b1
    } spi_state_e;

    // SPI mode encodings as {CPOL, CPHA}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    // A transition away from the idle level. Passing ~cpol yields the trailing edge.
    function automatic logic lead_edge(input logic cpol, input logic prev, input logic cur);
        return (prev == cpol) && (cur != cpol);
    endfunction

    // CPHA=0 samples MOSI on the leading edge, CPHA=1 on the trailing edge.
    function automatic logic sample_is_lead(input logic cpha);
        return ~cpha;
    endfunction

endpackage

// File: rtl/spi_slave_ctrl_if.sv
// Pin- and system-side signal bundle of the SPI target controller.
// Latency: none (wires only). Backpressure: TX uses tx_valid/tx_ready; RX has none.
// Modports: slave = controller view (the RTL), master = pin driver / system logic view.
interface spi_slave_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  sck;
    logic                  cs_n;
    logic                  mosi;
    logic                  miso;
    logic                  miso_oe;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  tx_underrun;
    logic                  frame_abort;
    logic                  busy;

    modport slave (
        input  sck, cs_n, mosi, tx_data, tx_valid,
        output miso, miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, frame_abort, busy
    );

    modport master (
        output sck, cs_n, mosi, tx_data, tx_valid,
        input  miso, miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, frame_abort, busy
    );
endinterface

// File: rtl/spi_slave_ctrl_sync.sv
// Multi-flop synchronizer for one asynchronous input bit.
// Latency: STAGES clk cycles. Backpressure: none.
// Ports: clk, rst_n (async active-low), d_i (async input), q_o (synchronized output).
module spi_sync #(
    parameter int STAGES  = 2,
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);
    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/spi_slave_ctrl.sv
// Full-duplex SPI target: oversamples SCK/CS_n/MOSI on clk, shifts RX words in and TX words out.
// Latency: pin to internal SYNC_STAGES+1 clk; rx_valid one clk after the completing sample edge.
// Backpressure: TX holding register via tx_valid/tx_ready; RX has none (new word overwrites rx_data).
// Ports: clk, rst_n (async active-low), bus (spi_slave_ctrl_if.slave: SPI pins + TX/RX handshake + status).
module spi_slave_ctrl #(
    parameter int                    DATA_WIDTH  = 8,
    parameter bit                    CPOL        = 1'b0,
    parameter bit                    CPHA        = 1'b0,
    parameter bit                    LSB_FIRST   = 1'b0,
    parameter int                    SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] TX_IDLE     = '1
) (
    input logic             clk,
    input logic             rst_n,
    spi_slave_ctrl_if.slave bus
);
    import spi_pkg::*;

    localparam int CW = $clog2(DATA_WIDTH);
    localparam int FW = $clog2(SYNC_STAGES + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    logic sck_s, cs_s, mosi_s;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sync_sck (
        .clk(clk), .rst_n(rst_n), .d_i(bus.sck), .q_o(sck_s));
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .d_i(bus.cs_n), .q_o(cs_s));
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .d_i(bus.mosi), .q_o(mosi_s));

    spi_state_e            state_q, state_d;
    logic                  sck_q;
    logic [FW-1:0]         flush_q, flush_d;
    logic                  armed_q, armed_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  hold_full_q, hold_full_d;
    logic                  underrun_q, underrun_d;
    logic                  abort_q, abort_d;
    logic                  load_w;

    logic lead_w, trail_w, sample_w, shift_w;
    assign lead_w   = lead_edge(CPOL, sck_q, sck_s);
    assign trail_w  = lead_edge(~CPOL, sck_q, sck_s);
    assign sample_w = sample_is_lead(CPHA) ? lead_w  : trail_w;
    assign shift_w  = sample_is_lead(CPHA) ? trail_w : lead_w;

    always_comb begin
        state_d     = state_q;
        flush_d     = flush_q;
        armed_d     = armed_q;
        cnt_d       = cnt_q;
        rx_sh_d     = rx_sh_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        tx_sh_d     = tx_sh_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        underrun_d  = 1'b0;
        abort_d     = 1'b0;
        load_w      = 1'b0;

        // After reset the cs_n synchronizer still holds its reset value; only arm once the
        // real pin level has flushed through and been seen high, so a CS held low across
        // reset cannot start a frame.
        if (flush_q != FW'(SYNC_STAGES)) begin
            flush_d = flush_q + FW'(1);
        end else if (cs_s) begin
            armed_d = 1'b1;
        end

        case (state_q)
            SPI_IDLE: begin
                cnt_d = '0;
                if (armed_q && !cs_s) begin
                    state_d = SPI_ACTIVE;
                    load_w  = ~CPHA;
                end
            end
            SPI_ACTIVE: begin
                if (sample_w) begin
                    rx_sh_d = LSB_FIRST ? {mosi_s, rx_sh_q[DATA_WIDTH-1:1]}
                                        : {rx_sh_q[DATA_WIDTH-2:0], mosi_s};
                    if (cnt_q == LAST_BIT) begin
                        cnt_d      = '0;
                        rx_data_d  = rx_sh_d;
                        rx_valid_d = 1'b1;
                        load_w     = ~CPHA;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                // A shift edge with the counter at 0 is either the CPHA=1 load edge or,
                // for CPHA=0, the trailing edge right after a word completed (no shift).
                if (shift_w) begin
                    if (cnt_q != '0) begin
                        tx_sh_d = LSB_FIRST ? {1'b0, tx_sh_q[DATA_WIDTH-1:1]}
                                            : {tx_sh_q[DATA_WIDTH-2:0], 1'b0};
                    end else begin
                        load_w = CPHA;
                    end
                end
                // Deselect: a word finishing on this very cycle already wrapped cnt_d to 0.
                if (cs_s) begin
                    state_d = SPI_IDLE;
                    abort_d = (cnt_d != '0);
                    cnt_d   = '0;
                    tx_sh_d = '0;
                    load_w  = 1'b0;
                end
            end
            default: state_d = SPI_IDLE;
        endcase

        if (load_w) begin
            if (hold_full_q) begin
                tx_sh_d     = hold_q;
                hold_full_d = 1'b0;
            end else begin
                tx_sh_d    = TX_IDLE;
                underrun_d = 1'b1;
            end
        end

        if (bus.tx_valid && !hold_full_q) begin
            hold_d      = bus.tx_data;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SPI_IDLE;
            sck_q       <= CPOL;
            flush_q     <= '0;
            armed_q     <= 1'b0;
            cnt_q       <= '0;
            rx_sh_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            tx_sh_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            underrun_q  <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sck_q       <= sck_s;
            flush_q     <= flush_d;
            armed_q     <= armed_d;
            cnt_q       <= cnt_d;
            rx_sh_q     <= rx_sh_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_sh_q     <= tx_sh_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            underrun_q  <= underrun_d;
            abort_q     <= abort_d;
        end
    end

    assign bus.miso        = (state_q == SPI_ACTIVE) &&
                             (LSB_FIRST ? tx_sh_q[0] : tx_sh_q[DATA_WIDTH-1]);
    assign bus.miso_oe     = ~cs_s;
    assign bus.tx_ready    = ~hold_full_q;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.tx_underrun = underrun_q;
    assign bus.frame_abort = abort_q;
    assign bus.busy        = (state_q == SPI_ACTIVE);
endmodule
